// File: rtl/tdp_burst_reader.sv
// Burst read master for one port of the true-dual-port activation/weight buffer.
// Streams base..base+len-1 (wrapping at MEM_DEPTH) out on a valid/ready interface.
module tdp_burst_reader #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 15,
  parameter int MEM_DEPTH = 20480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;

  logic cmd_fire;
  logic out_free;
  logic out_fire;

  // Address wraps at the physical buffer depth, not at the power of two.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  assign cmd_fire = cmd_valid && (state_q == IDLE);
  assign out_free = !out_valid_q || out_ready;
  assign out_fire = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire && (cmd_len != '0)) state_d = READ;
      READ:    if (out_free && (remaining_q == LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (out_fire && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture stage: mem_dout is combinational from mem_addr_q and lands in the output register.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          mem_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          done_d      = (cmd_len == '0);
        end
      end
      READ: begin
        if (out_free) begin
          out_data_d  = mem_dout;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == LEN_W'(1));
          mem_addr_d  = next_addr(mem_addr_q);
          remaining_d = remaining_q - LEN_W'(1);
        end
      end
      DRAIN: begin
        if (out_fire && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    mem_addr  = mem_addr_q;
    mem_we    = 1'b0;
    mem_din   = '0;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_last  = out_last_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_tdp_burst_reader.sv
// Randomized bench for tdp_burst_reader: a behavioural buffer model plus a
// scoreboard that predicts each beat as mem[(base+k) mod depth].
module tb_tdp_burst_reader;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 15;
  localparam int DEPTH  = 20480;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [DEPTH];
  bit                bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mem_dout = (int'(mem_addr) < DEPTH) ? mem[mem_addr] : '0;

  tdp_burst_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap(input int a);
    return a % DEPTH;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_we"},    mem_we, 0);
    chk({tag, "_mem_din"},   mem_din, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_out_last"},  out_last, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
  endtask

  // mode 0: out_ready high; 1: random; 2: fixed stall pattern from the first word
  task automatic run_burst(input int addr, input int len, input int mode, input bit inject);
    int c, k, last_hs, budget;
    bit prev_stall, finished;
    logic [DATA_W-1:0] pd;
    logic              pl;
    logic [ADDR_W-1:0] pa;

    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = LEN_W'(len);
    step();
    cmd_valid = 1'b0;
    cmd_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
    c = 1;
    chk("t1_mem_addr", mem_addr, addr);
    chk("t1_out_valid", out_valid, 0);
    if (len == 0) begin
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      chk("len0_cmd_ready", cmd_ready, 1);
      step();
      chk("len0_done_clear", done, 0);
      chk("len0_no_valid", out_valid, 0);
      chk("len0_busy_after", busy, 0);
      return;
    end
    chk("t1_busy", busy, 1);
    chk("t1_done", done, 0);
    chk("t1_cmd_ready", cmd_ready, 0);

    k = 0; last_hs = -1; prev_stall = 1'b0; finished = 1'b0;
    pd = '0; pl = 1'b0; pa = '0;
    budget = 6 * len + 40;
    while (!finished) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = (c >= 2 && c - 2 < 7) ? bp_pat[c - 2] : 1'b1;
      endcase
      if (inject) begin
        cmd_valid = (c == 3);
        cmd_addr  = ADDR_W'(wrap(addr + 100));
        cmd_len   = LEN_W'(5);
        if (c == 3) chk("busy_cmd_ready", cmd_ready, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
        chk("stall_mem_addr", mem_addr, pa);
      end
      if (mode == 0 && c <= len) chk("mem_addr_seq", mem_addr, wrap(addr + c - 1));
      if (done) begin
        chk("done_beats", k, len);
        chk("done_after_last_hs", c, last_hs + 1);
        if (mode == 0) chk("done_cycle", c, 2 + len);
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_busy", busy, 0);
        chk("done_out_valid", out_valid, 0);
        finished = 1'b1;
      end else if (out_valid && out_ready) begin
        if (k >= len) begin
          chk("extra_beat", k, len - 1);
        end else begin
          chk("beat_data", out_data, mem[wrap(addr + k)]);
          chk("beat_last", out_last, (k == len - 1));
          if (mode == 0) chk("beat_cycle", c, 2 + k);
        end
        k++;
        last_hs = c;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      pa = mem_addr;
      if (!finished) begin
        if (c > budget) begin
          chk("burst_timeout", 0, 1);
          finished = 1'b1;
        end else begin
          step();
          c++;
        end
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic reset_mid_burst();
    int addr;
    addr = 300;
    out_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = LEN_W'(6);
    step();
    cmd_valid = 1'b0;
    step();
    chk("rstmid_beat0", out_data, mem[addr]);
    step();
    chk("rstmid_beat1", out_data, mem[addr + 1]);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rstmid");
    step();
    chk("rstmid_no_done", done, 0);
    chk("rstmid_no_valid", out_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    repeat (3) step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) mem[16 + i] = DATA_W'(16'hA000 + i);
    run_burst(16, 4, 0, 1'b0);
    step();
    run_burst(16, 4, 2, 1'b0);

    mem[20478] = 16'h1111;
    mem[20479] = 16'h2222;
    mem[0]     = 16'h3333;
    run_burst(20478, 3, 0, 1'b0);

    run_burst(5, 0, 0, 1'b0);
    run_burst(7, 1, 0, 1'b0);
    run_burst(9, 1, 1, 1'b0);
    run_burst(200, 8, 0, 1'b1);

    reset_mid_burst();
    run_burst(16, 4, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int a, l, m;
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1)
                                      : $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 10);
      m = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) step();
      run_burst(a, l, m, 1'b0);
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
